// File: rtl/arp_lookup_req_if.sv
`default_nettype none
// ============================================================================
// Module  : arp_lookup_req_if
// Brief   : Bundle of the ingress stream, the CAM lookup handshake and the
//           verdict FIFO port that surround the ARP lookup initiator.
// Revision: 1.0  initial release
// ============================================================================
interface arp_lookup_req_if;
  // Ingress AXI4-Stream (snooped; byte 0 of each beat sits in [63:56])
  logic [63:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tlast;
  logic        s_axis_tready;
  // CAM lookup request / response
  logic        look_req;
  logic [47:0] src_ip;
  logic [47:0] dst_ip;
  logic [15:0] opcode;
  logic        lookup_done;
  logic        lut_hit;
  logic        lut_miss;
  logic        attack;
  // Verdict FIFO read side
  logic        verdict_valid;
  logic        verdict_ready;
  logic [3:0]  verdict_data;

  // The lookup initiator itself
  modport slave (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast,
    output s_axis_tready,
    output look_req, src_ip, dst_ip, opcode,
    input  lookup_done, lut_hit, lut_miss, attack,
    output verdict_valid, verdict_data,
    input  verdict_ready
  );

  // The surrounding stream source, CAM and dropper
  modport master (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast,
    input  s_axis_tready,
    input  look_req, src_ip, dst_ip, opcode,
    output lookup_done, lut_hit, lut_miss, attack,
    input  verdict_valid, verdict_data,
    output verdict_ready
  );
endinterface
`default_nettype wire

// File: rtl/arp_lookup_req.sv
`default_nettype none
// ============================================================================
// Module  : arp_lookup_req
// Brief   : Snoops the ingress stream, extracts ARP oper/SPA/TPA, issues one
//           CAM lookup per ARP frame and queues one verdict per frame
//           ({drop, is_arp, hit, timeout}) for the downstream dropper.
// Revision: 1.0  initial release
// ============================================================================
module arp_lookup_req #(
  parameter int TIMEOUT_CYCLES     = 64,
  parameter int VERDICT_FIFO_DEPTH = 4
) (
  input  wire logic       clk,
  input  wire logic       reset,
  arp_lookup_req_if.slave bus,
  output logic [31:0]     arp_count,
  output logic [31:0]     drop_count
);

  localparam int PTR_W = $clog2(VERDICT_FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] FIFO_FULL = CNT_W'(VERDICT_FIFO_DEPTH);
  localparam logic [15:0]      ETH_ARP   = 16'h0806;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    HDR       = 3'd1,
    LOOKUP    = 3'd2,
    WAIT_DONE = 3'd3,
    BODY      = 3'd4,
    WRITE     = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [2:0]         beat_cnt_q, beat_cnt_d;
  logic [15:0]        ethertype_q, ethertype_d;
  logic [15:0]        oper_q, oper_d;
  logic [31:0]        spa_q, spa_d;
  logic [15:0]        tpa_hi_q, tpa_hi_d;
  logic               tlast_seen_q, tlast_seen_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [3:0]         verdict_q, verdict_d;      // {drop, is_arp, hit, timeout}
  logic [47:0]        src_ip_q, src_ip_d;
  logic [47:0]        dst_ip_q, dst_ip_d;
  logic [15:0]        opcode_q, opcode_d;
  logic [31:0]        arp_count_q, arp_count_d;
  logic [31:0]        drop_count_q, drop_count_d;
  logic [3:0]         fifo_mem_q [VERDICT_FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic tready;
  logic accept;
  logic fifo_full;
  logic pop;
  logic push;
  logic unused_tdata;

  // Bytes 42-47 of beat 5 carry nothing the lookup needs
  assign unused_tdata = ^bus.s_axis_tdata[47:32];

  assign tready    = (state_q == IDLE) || (state_q == HDR) || (state_q == BODY);
  assign accept    = bus.s_axis_tvalid && tready;
  assign fifo_full = (count_q == FIFO_FULL);
  assign pop       = bus.verdict_valid && bus.verdict_ready;
  // A full FIFO still takes a push in the cycle the head is popped
  assign push      = (state_q == WRITE) && (!fifo_full || pop);

  assign bus.s_axis_tready = tready;
  assign bus.look_req      = (state_q == LOOKUP);
  assign bus.src_ip        = src_ip_q;
  assign bus.dst_ip        = dst_ip_q;
  assign bus.opcode        = opcode_q;
  assign bus.verdict_valid = (count_q != '0);
  assign bus.verdict_data  = fifo_mem_q[rd_ptr_q];
  assign arp_count         = arp_count_q;
  assign drop_count        = drop_count_q;

  // Frame parser, lookup sequencer and verdict builder
  always_comb begin
    state_d      = state_q;
    beat_cnt_d   = beat_cnt_q;
    ethertype_d  = ethertype_q;
    oper_d       = oper_q;
    spa_d        = spa_q;
    tpa_hi_d     = tpa_hi_q;
    tlast_seen_d = tlast_seen_q;
    timer_d      = timer_q;
    verdict_d    = verdict_q;
    src_ip_d     = src_ip_q;
    dst_ip_d     = dst_ip_q;
    opcode_d     = opcode_q;
    arp_count_d  = arp_count_q;
    drop_count_d = drop_count_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          beat_cnt_d   = 3'd1;
          verdict_d    = 4'b0000;
          tlast_seen_d = 1'b0;
          state_d      = bus.s_axis_tlast ? WRITE : HDR;
        end
      end
      HDR: begin
        if (accept) begin
          if (beat_cnt_q != 3'd7) beat_cnt_d = beat_cnt_q + 3'd1;
          case (beat_cnt_q)
            3'd1:    ethertype_d = bus.s_axis_tdata[31:16];
            3'd2:    oper_d      = bus.s_axis_tdata[31:16];
            3'd3:    spa_d       = bus.s_axis_tdata[31:0];
            3'd4:    tpa_hi_d    = bus.s_axis_tdata[15:0];
            default: ;
          endcase
          if (beat_cnt_q == 3'd5) begin
            if (ethertype_q == ETH_ARP) begin
              // TPA low half arrives on this very beat, so take it straight off the bus
              state_d      = LOOKUP;
              tlast_seen_d = bus.s_axis_tlast;
              src_ip_d     = {16'h0000, spa_q};
              dst_ip_d     = {16'h0000, tpa_hi_q, bus.s_axis_tdata[63:48]};
              opcode_d     = oper_q;
            end else begin
              state_d = bus.s_axis_tlast ? WRITE : BODY;
            end
          end else if (bus.s_axis_tlast) begin
            state_d = WRITE;
          end
        end
      end
      LOOKUP: begin
        timer_d      = '0;
        verdict_d[2] = 1'b1;
        if (arp_count_q != 32'hFFFF_FFFF) arp_count_d = arp_count_q + 32'd1;
        state_d      = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (bus.lookup_done) begin
          verdict_d = {bus.attack, 1'b1, bus.lut_hit, 1'b0};
          state_d   = tlast_seen_q ? WRITE : BODY;
        end else if (timer_q == TMR_LAST) begin
          verdict_d = 4'b0101;
          state_d   = tlast_seen_q ? WRITE : BODY;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      BODY: begin
        if (accept) begin
          if (beat_cnt_q != 3'd7) beat_cnt_d = beat_cnt_q + 3'd1;
          if (bus.s_axis_tlast) state_d = WRITE;
        end
      end
      WRITE: begin
        if (push) begin
          if (verdict_q[3] && (drop_count_q != 32'hFFFF_FFFF)) drop_count_d = drop_count_q + 32'd1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Verdict FIFO pointer and occupancy update
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: ;
    endcase
  end

  // Control, capture and counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      beat_cnt_q   <= 3'd0;
      ethertype_q  <= 16'h0000;
      oper_q       <= 16'h0000;
      spa_q        <= 32'h0000_0000;
      tpa_hi_q     <= 16'h0000;
      tlast_seen_q <= 1'b0;
      timer_q      <= '0;
      verdict_q    <= 4'b0000;
      src_ip_q     <= 48'h0;
      dst_ip_q     <= 48'h0;
      opcode_q     <= 16'h0000;
      arp_count_q  <= 32'h0;
      drop_count_q <= 32'h0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      beat_cnt_q   <= beat_cnt_d;
      ethertype_q  <= ethertype_d;
      oper_q       <= oper_d;
      spa_q        <= spa_d;
      tpa_hi_q     <= tpa_hi_d;
      tlast_seen_q <= tlast_seen_d;
      timer_q      <= timer_d;
      verdict_q    <= verdict_d;
      src_ip_q     <= src_ip_d;
      dst_ip_q     <= dst_ip_d;
      opcode_q     <= opcode_d;
      arp_count_q  <= arp_count_d;
      drop_count_q <= drop_count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

  // Verdict storage; written at the tail on every push
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < VERDICT_FIFO_DEPTH; i++) fifo_mem_q[i] <= 4'b0000;
    end else if (push) begin
      fifo_mem_q[wr_ptr_q] <= verdict_q;
    end
  end

  // The CAM must never report a hit and a miss for the same lookup
  assert property (@(posedge clk) disable iff (reset)
                   !(bus.lookup_done && bus.lut_hit && bus.lut_miss));

endmodule
`default_nettype wire

// File: tb/tb_arp_lookup_req.sv
`default_nettype none
// ============================================================================
// Module  : tb_arp_lookup_req
// Brief   : Directed bench for arp_lookup_req with a byte-level frame model,
//           an automatic CAM responder and a per-cycle compare process.
// Revision: 1.0  initial release
// ============================================================================
module tb_arp_lookup_req;

  localparam int TIMEOUT = 64;
  localparam int DEPTH   = 4;

  typedef struct {
    logic [47:0] src;
    logic [47:0] dst;
    logic [15:0] op;
  } look_t;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] arp_count;
  logic [31:0] drop_count;

  arp_lookup_req_if bus();

  arp_lookup_req #(
    .TIMEOUT_CYCLES     (TIMEOUT),
    .VERDICT_FIFO_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .arp_count  (arp_count),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  int          checks    = 0;
  int          failures  = 0;
  int          stall_cnt = 0;
  int          pops      = 0;
  logic [3:0]  last_pop  = 4'h0;
  int          resp_delay  = -1;
  bit          resp_hit    = 1'b0;
  bit          resp_attack = 1'b0;
  logic [7:0]  frm [64];
  look_t       exp_look_q [$];
  logic [3:0]  exp_v_q [$];
  int          exp_arp  = 0;
  int          exp_drop = 0;
  look_t       cmp_e;
  int          pops_mark;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ARP request/reply frame; padding and unused fields are non-zero on purpose
  task automatic build_arp(input logic [15:0] oper, input logic [31:0] spa, input logic [31:0] tpa);
    for (int i = 0; i < 64; i++) frm[i] = 8'h5A;
    for (int i = 0; i < 6; i++) frm[i] = 8'hFF;
    for (int i = 0; i < 6; i++) frm[6 + i] = 8'h20 + 8'(i);
    frm[12] = 8'h08; frm[13] = 8'h06;
    frm[14] = 8'h00; frm[15] = 8'h01; frm[16] = 8'h08; frm[17] = 8'h00;
    frm[18] = 8'h06; frm[19] = 8'h04;
    frm[20] = oper[15:8]; frm[21] = oper[7:0];
    for (int i = 0; i < 6; i++) frm[22 + i] = 8'h20 + 8'(i);
    for (int i = 0; i < 4; i++) frm[28 + i] = spa[31 - 8*i -: 8];
    for (int i = 0; i < 6; i++) frm[32 + i] = 8'hA5;
    for (int i = 0; i < 4; i++) frm[38 + i] = tpa[31 - 8*i -: 8];
  endtask

  task automatic build_eth(input logic [15:0] etype);
    for (int i = 0; i < 64; i++) frm[i] = 8'(i * 7 + 3);
    frm[12] = etype[15:8]; frm[13] = etype[7:0];
  endtask

  // Frame-level model: an ARP frame is one whose beat 5 exists and whose ethertype is 0806
  task automatic model_frame(input int nbeats, input int d, input bit h, input bit a, input bit with_verdict);
    logic [15:0] et;
    bit          is_arp;
    look_t       e;
    et     = {frm[12], frm[13]};
    is_arp = (nbeats >= 6) && (et == 16'h0806);
    if (is_arp) begin
      e.src = {16'h0000, frm[28], frm[29], frm[30], frm[31]};
      e.dst = {16'h0000, frm[38], frm[39], frm[40], frm[41]};
      e.op  = {frm[20], frm[21]};
      exp_look_q.push_back(e);
      exp_arp++;
    end
    if (with_verdict) begin
      if (!is_arp) begin
        exp_v_q.push_back(4'b0000);
      end else if (d >= 1 && d <= TIMEOUT) begin
        exp_v_q.push_back({a, 1'b1, h, 1'b0});
        if (a) exp_drop++;
      end else begin
        exp_v_q.push_back(4'b0101);
      end
    end
  endtask

  task automatic send_beat(input int k, input bit last);
    logic [63:0] beat;
    bit          got;
    for (int b = 0; b < 8; b++) beat[63 - 8*b -: 8] = frm[8*k + b];
    bus.s_axis_tdata  = beat;
    bus.s_axis_tvalid = 1'b1;
    bus.s_axis_tlast  = last;
    got = 1'b0;
    for (int w = 0; w < 300 && !got; w++) begin
      @(negedge clk);
      if (bus.s_axis_tready) got = 1'b1;
      else stall_cnt++;
    end
    if (!got) chk("beat_accept_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast  = 1'b0;
  endtask

  task automatic send_frame(input int nbeats, input int d, input bit h, input bit a);
    resp_delay  = d;
    resp_hit    = h;
    resp_attack = a;
    model_frame(nbeats, d, h, a, 1'b1);
    stall_cnt = 0;
    for (int k = 0; k < nbeats; k++) send_beat(k, k == nbeats - 1);
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((exp_v_q.size() != 0 || bus.verdict_valid) && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (w >= 300) chk("drain_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
  endtask

  // CAM responder: answers each look_req after resp_delay cycles (never if <= 0)
  initial begin
    int  d;
    bit  h, a;
    bus.lookup_done = 1'b0;
    bus.lut_hit     = 1'b0;
    bus.lut_miss    = 1'b0;
    bus.attack      = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.look_req && !reset) begin
        d = resp_delay; h = resp_hit; a = resp_attack;
        if (d > 0) begin
          repeat (d) @(posedge clk);
          #1;
          bus.lookup_done = 1'b1;
          bus.lut_hit     = h;
          bus.lut_miss    = !h;
          bus.attack      = a;
          @(posedge clk); #1;
          bus.lookup_done = 1'b0;
          bus.lut_hit     = 1'b0;
          bus.lut_miss    = 1'b0;
          bus.attack      = 1'b0;
        end
      end
    end
  end

  // Compare process: every lookup request and every popped verdict against the model
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.look_req) begin
        if (exp_look_q.size() == 0) begin
          chk("unexpected_look_req", 64'd1, 64'd0);
        end else begin
          cmp_e = exp_look_q.pop_front();
          chk("look_src_ip", bus.src_ip, cmp_e.src);
          chk("look_dst_ip", bus.dst_ip, cmp_e.dst);
          chk("look_opcode", bus.opcode, cmp_e.op);
          chk("look_tready", bus.s_axis_tready, 64'd0);
        end
      end
      if (bus.verdict_valid && bus.verdict_ready) begin
        if (exp_v_q.size() == 0) chk("unexpected_verdict", bus.verdict_data, 64'hF0);
        else chk("verdict_data", bus.verdict_data, exp_v_q.pop_front());
        last_pop = bus.verdict_data;
        pops++;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.s_axis_tdata  = '0;
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast  = 1'b0;
    bus.verdict_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_tready",   bus.s_axis_tready, 64'd1);
    chk("rst_look_req", bus.look_req, 64'd0);
    chk("rst_vvalid",   bus.verdict_valid, 64'd0);
    chk("rst_src_ip",   bus.src_ip, 64'd0);
    chk("rst_dst_ip",   bus.dst_ip, 64'd0);
    chk("rst_opcode",   bus.opcode, 64'd0);
    chk("rst_arp_cnt",  arp_count, 64'd0);
    chk("rst_drop_cnt", drop_count, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // 1: ARP 10.0.0.1 -> 10.0.0.2 oper 1, hit after 3 cycles
    build_arp(16'h0001, 32'h0A00_0001, 32'h0A00_0002);
    send_frame(8, 3, 1'b1, 1'b0);
    chk("t1_stall", stall_cnt, 64'd4);
    drain();
    chk("t1_src_ip", bus.src_ip, 64'h0000_0A00_0001);
    chk("t1_dst_ip", bus.dst_ip, 64'h0000_0A00_0002);
    chk("t1_opcode", bus.opcode, 64'd1);
    chk("t1_verdict", last_pop, 64'b0110);
    chk("t1_arp_cnt", arp_count, 64'd1);

    // 2: same frame flagged as an attack
    send_frame(8, 3, 1'b1, 1'b1);
    chk("t2_stall", stall_cnt, 64'd4);
    drain();
    chk("t2_verdict", last_pop, 64'b1110);
    chk("t2_drop_cnt", drop_count, 64'd1);

    // 3: IPv4 frame then a 3-beat ARP-typed runt; neither looks up
    pops_mark = pops;
    build_eth(16'h0800);
    send_frame(8, 3, 1'b0, 1'b0);
    build_arp(16'h0001, 32'h0A00_0001, 32'h0A00_0002);
    send_frame(3, 3, 1'b0, 1'b0);
    drain();
    chk("t3_pops", pops - pops_mark, 64'd2);
    chk("t3_verdict", last_pop, 64'b0000);
    chk("t3_arp_cnt", arp_count, 64'd2);

    // ARP frame ending on beat 5 with a miss goes straight to WRITE after the lookup
    build_arp(16'h0002, 32'hC0A8_0105, 32'hC0A8_0101);
    send_frame(6, 3, 1'b0, 1'b0);
    drain();
    chk("t3b_verdict", last_pop, 64'b0100);
    chk("t3b_dst_ip", bus.dst_ip, 64'h0000_C0A8_0101);

    // 4: timer boundary - answer on the last allowed cycle, then one cycle too late
    build_arp(16'h0001, 32'h0A00_0003, 32'h0A00_0004);
    send_frame(8, TIMEOUT, 1'b1, 1'b0);
    chk("t4_edge_stall", stall_cnt, 64'd65);
    drain();
    chk("t4_edge_verdict", last_pop, 64'b0110);
    send_frame(8, TIMEOUT + 1, 1'b1, 1'b1);
    chk("t4_late_stall", stall_cnt, 64'd65);
    drain();
    chk("t4_late_verdict", last_pop, 64'b0101);
    send_frame(8, 80, 1'b1, 1'b1);
    drain();
    repeat (25) @(posedge clk);
    #1;
    chk("t4_to_verdict", last_pop, 64'b0101);
    chk("t4_drop_cnt", drop_count, 64'd1);
    chk("t4_no_extra", bus.verdict_valid, 64'd0);

    // 5: FIFO fills with five back-to-back runts while the dropper is stalled
    bus.verdict_ready = 1'b0;
    pops_mark = pops;
    build_eth(16'h86DD);
    for (int f = 0; f < 5; f++) send_frame(2, 3, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    chk("t5_full_tready", bus.s_axis_tready, 64'd0);
    chk("t5_full_valid", bus.verdict_valid, 64'd1);
    @(posedge clk); #1;
    bus.verdict_ready = 1'b1;
    @(posedge clk); #1;
    bus.verdict_ready = 1'b0;
    @(negedge clk);
    chk("t5_resume_tready", bus.s_axis_tready, 64'd1);
    chk("t5_one_pop", pops - pops_mark, 64'd1);
    chk("t5_still_valid", bus.verdict_valid, 64'd1);
    @(posedge clk); #1;
    bus.verdict_ready = 1'b1;
    drain();
    chk("t5_total_pops", pops - pops_mark, 64'd5);

    // Mixed verdicts queued while stalled must come out in frame order
    bus.verdict_ready = 1'b0;
    build_arp(16'h0001, 32'h0A00_0011, 32'h0A00_0012);
    send_frame(8, 3, 1'b1, 1'b0);
    build_eth(16'h0800);
    send_frame(4, 3, 1'b0, 1'b0);
    build_arp(16'h0002, 32'h0A00_0021, 32'h0A00_0022);
    send_frame(8, 3, 1'b1, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    bus.verdict_ready = 1'b1;
    drain();
    chk("t5b_last", last_pop, 64'b1110);
    chk("t5b_drop_cnt", drop_count, 64'd2);

    // 6: reset while waiting for the CAM
    build_arp(16'h0001, 32'h0A00_0031, 32'h0A00_0032);
    resp_delay = -1;
    model_frame(6, -1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 6; k++) send_beat(k, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    chk("t6_look_issued", exp_look_q.size(), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("t6_look_req", bus.look_req, 64'd0);
    chk("t6_vvalid", bus.verdict_valid, 64'd0);
    chk("t6_arp_cnt", arp_count, 64'd0);
    chk("t6_drop_cnt", drop_count, 64'd0);
    chk("t6_tready", bus.s_axis_tready, 64'd1);
    exp_arp  = 0;
    exp_drop = 0;
    exp_v_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    build_arp(16'h0001, 32'h0A00_0001, 32'h0A00_0002);
    send_frame(8, 3, 1'b1, 1'b0);
    drain();
    chk("t6_verdict", last_pop, 64'b0110);
    chk("t6_arp_after", arp_count, 64'd1);

    // Final bookkeeping against the model
    chk("end_look_q_empty", exp_look_q.size(), 64'd0);
    chk("end_verdict_q_empty", exp_v_q.size(), 64'd0);
    chk("end_arp_cnt", arp_count, 64'(exp_arp));
    chk("end_drop_cnt", drop_count, 64'(exp_drop));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
